// File: rtl/mips_pkg.sv
// Purpose: shared constants and types for the ID-stage branch operand forwarding slice.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: REG_ZERO, stall_state_t, per-hazard stall cycle counts, max2 helper.
package mips_pkg;

  // Register 0 is hard-wired to zero: it never creates a hazard and is never forwarded.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stall_state_t;

  // Total hold cycles required before the branch can safely read the operand.
  localparam logic [1:0] STALL_NONE     = 2'd0;
  localparam logic [1:0] STALL_LOAD_EX  = 2'd2;
  localparam logic [1:0] STALL_ALU_EX   = 2'd1;
  localparam logic [1:0] STALL_LOAD_MEM = 2'd1;

  function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/forward_mux.sv
// Purpose: selects one branch comparator operand from MEM ALU result, WB data or register file.
// Latency: combinational, zero cycles.
// Backpressure: none; the consumer ignores the value while the stall FSM holds ID.
// Ports: src (operand register index), mem*/wb* later-stage writer info, regFileData, data (selected operand).
module forward_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  src,
  input  logic              memRegWrite,
  input  logic              memMemRead,
  input  logic [REG_W-1:0]  memWriteReg,
  input  logic [DATA_W-1:0] memAluResult,
  input  logic              wbRegWrite,
  input  logic [REG_W-1:0]  wbWriteReg,
  input  logic [DATA_W-1:0] wbWriteData,
  input  logic [DATA_W-1:0] regFileData,
  output logic [DATA_W-1:0] data
);

  logic srcNonZero;
  logic memHit;
  logic wbHit;

  assign srcNonZero = (src != REG_W'(REG_ZERO));

  // A load in MEM has no data yet (only its address), so it is never a forwarding source.
  assign memHit = memRegWrite && (memWriteReg == src) && srcNonZero && !memMemRead;
  assign wbHit  = wbRegWrite && (wbWriteReg == src) && srcNonZero;

  // MEM is the younger writer, so it wins over WB.
  always_comb begin
    data = regFileData;
    if (memHit) begin
      data = memAluResult;
    end else if (wbHit) begin
      data = wbWriteData;
    end
  end

endmodule

// File: rtl/branch_operand_forward.sv
// Purpose: produces forwarded rs/rt operands for the ID branch comparator and stalls on branch data hazards.
// Latency: operands and first stall cycle are combinational; load-in-EX hazards hold one extra registered cycle.
// Backpressure: stallOutput/bubbleOutput hold PC and IF/ID and zero ID/EX control; STALL cycles ignore inputs.
// Ports: clock, reset (sync, active-high); ID branch info (idValid, idIsBranch, idUsesRt, idRs, idRt);
//        regFileRs/Rt; EX/MEM/WB writer info; dataRsOutput/dataRtOutput, stallOutput, bubbleOutput.
module branch_operand_forward
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              idValid,
  input  logic              idIsBranch,
  input  logic              idUsesRt,
  input  logic [REG_W-1:0]  idRs,
  input  logic [REG_W-1:0]  idRt,
  input  logic [DATA_W-1:0] regFileRs,
  input  logic [DATA_W-1:0] regFileRt,
  input  logic              exRegWrite,
  input  logic              exMemRead,
  input  logic [REG_W-1:0]  exWriteReg,
  input  logic              memRegWrite,
  input  logic              memMemRead,
  input  logic [REG_W-1:0]  memWriteReg,
  input  logic [DATA_W-1:0] memAluResult,
  input  logic              wbRegWrite,
  input  logic [REG_W-1:0]  wbWriteReg,
  input  logic [DATA_W-1:0] wbWriteData,
  output logic [DATA_W-1:0] dataRsOutput,
  output logic [DATA_W-1:0] dataRtOutput,
  output logic              stallOutput,
  output logic              bubbleOutput
);

  stall_state_t state;
  logic [1:0]   count;

  logic [DATA_W-1:0] fwdRs;
  logic [DATA_W-1:0] fwdRt;
  logic [1:0]        needRs;
  logic [1:0]        needRt;
  logic [1:0]        need;
  logic              stall;

  forward_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .src          (idRs),
    .memRegWrite  (memRegWrite),
    .memMemRead   (memMemRead),
    .memWriteReg  (memWriteReg),
    .memAluResult (memAluResult),
    .wbRegWrite   (wbRegWrite),
    .wbWriteReg   (wbWriteReg),
    .wbWriteData  (wbWriteData),
    .regFileData  (regFileRs),
    .data         (fwdRs)
  );

  forward_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .src          (idRt),
    .memRegWrite  (memRegWrite),
    .memMemRead   (memMemRead),
    .memWriteReg  (memWriteReg),
    .memAluResult (memAluResult),
    .wbRegWrite   (wbRegWrite),
    .wbWriteReg   (wbWriteReg),
    .wbWriteData  (wbWriteData),
    .regFileData  (regFileRt),
    .data         (fwdRt)
  );

  // Hold cycles one source register needs against the writers still in EX and MEM.
  function automatic logic [1:0] hazard_need(input logic [REG_W-1:0] src);
    logic nonZero;
    logic exHit;
    logic memHit;
    nonZero = (src != REG_W'(REG_ZERO));
    exHit   = exRegWrite && (exWriteReg == src) && nonZero;
    memHit  = memRegWrite && (memWriteReg == src) && nonZero;
    if (exHit && exMemRead) begin
      return STALL_LOAD_EX;
    end else if (exHit) begin
      return STALL_ALU_EX;
    end else if (memHit && memMemRead) begin
      return STALL_LOAD_MEM;
    end
    return STALL_NONE;
  endfunction

  always_comb begin
    needRs = hazard_need(idRs);
    needRt = idUsesRt ? hazard_need(idRt) : STALL_NONE;
    need   = STALL_NONE;
    // Hazards are only evaluated in IDLE; STALL runs off the pre-loaded count.
    if ((state == IDLE) && idValid && idIsBranch) begin
      need = max2(needRs, needRt);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          // The IDLE cycle itself is the first hold cycle; STALL covers the rest.
          if (need > 2'd1) begin
            state <= STALL;
            count <= need - 2'd1;
          end
        end
        STALL: begin
          if (count <= 2'd1) begin
            state <= IDLE;
            count <= 2'd0;
          end else begin
            count <= count - 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          count <= 2'd0;
        end
      endcase
    end
  end

  assign stall = (state == STALL) || (need != STALL_NONE);

  assign stallOutput  = !reset && stall;
  assign bubbleOutput = !reset && stall;
  assign dataRsOutput = reset ? '0 : fwdRs;
  assign dataRtOutput = reset ? '0 : fwdRt;

endmodule

// File: tb/tb_branch_operand_forward.sv
// Purpose: directed self-checking bench for branch_operand_forward.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_branch_operand_forward;

  logic        clock;
  logic        reset;
  logic        idValid;
  logic        idIsBranch;
  logic        idUsesRt;
  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic [31:0] regFileRs;
  logic [31:0] regFileRt;
  logic        exRegWrite;
  logic        exMemRead;
  logic [4:0]  exWriteReg;
  logic        memRegWrite;
  logic        memMemRead;
  logic [4:0]  memWriteReg;
  logic [31:0] memAluResult;
  logic        wbRegWrite;
  logic [4:0]  wbWriteReg;
  logic [31:0] wbWriteData;
  logic [31:0] dataRsOutput;
  logic [31:0] dataRtOutput;
  logic        stallOutput;
  logic        bubbleOutput;

  int total;
  int bad;

  branch_operand_forward #(.DATA_W(32), .REG_W(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .idValid      (idValid),
    .idIsBranch   (idIsBranch),
    .idUsesRt     (idUsesRt),
    .idRs         (idRs),
    .idRt         (idRt),
    .regFileRs    (regFileRs),
    .regFileRt    (regFileRt),
    .exRegWrite   (exRegWrite),
    .exMemRead    (exMemRead),
    .exWriteReg   (exWriteReg),
    .memRegWrite  (memRegWrite),
    .memMemRead   (memMemRead),
    .memWriteReg  (memWriteReg),
    .memAluResult (memAluResult),
    .wbRegWrite   (wbRegWrite),
    .wbWriteReg   (wbWriteReg),
    .wbWriteData  (wbWriteData),
    .dataRsOutput (dataRsOutput),
    .dataRtOutput (dataRtOutput),
    .stallOutput  (stallOutput),
    .bubbleOutput (bubbleOutput)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    idValid      = 1'b0;
    idIsBranch   = 1'b0;
    idUsesRt     = 1'b0;
    idRs         = 5'd0;
    idRt         = 5'd0;
    regFileRs    = 32'h0;
    regFileRt    = 32'h0;
    exRegWrite   = 1'b0;
    exMemRead    = 1'b0;
    exWriteReg   = 5'd0;
    memRegWrite  = 1'b0;
    memMemRead   = 1'b0;
    memWriteReg  = 5'd0;
    memAluResult = 32'h0;
    wbRegWrite   = 1'b0;
    wbWriteReg   = 5'd0;
    wbWriteData  = 32'h0;
  endtask

  task automatic branch(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt);
    idValid    = 1'b1;
    idIsBranch = 1'b1;
    idUsesRt   = usesRt;
    idRs       = rs;
    idRt       = rt;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_inputs();

    // 1: reset held 3 cycles with an exact EX load hazard present
    reset = 1'b1;
    branch(5'd9, 5'd9, 1'b1);
    regFileRs  = 32'hDEAD_0001;
    regFileRt  = 32'hBEEF_0002;
    exRegWrite = 1'b1;
    exMemRead  = 1'b1;
    exWriteReg = 5'd9;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rst_stall", 32'(stallOutput), 32'd0);
      check("rst_bubble", 32'(bubbleOutput), 32'd0);
      check("rst_rs", dataRsOutput, 32'h0);
      check("rst_rt", dataRtOutput, 32'h0);
      tick();
    end
    reset = 1'b0;
    clear_inputs();
    sample();
    check("idle_after_rst", 32'(stallOutput), 32'd0);
    tick();

    // 2: ALU result for r8 sitting in MEM forwarded to rs
    branch(5'd8, 5'd0, 1'b0);
    memRegWrite  = 1'b1;
    memWriteReg  = 5'd8;
    memAluResult = 32'd5;
    sample();
    check("mem_fwd_rs", dataRsOutput, 32'd5);
    check("mem_fwd_stall", 32'(stallOutput), 32'd0);
    tick();

    // 3: load to r9 in EX, branch reads rt=r9 -> two hold cycles, then WB forward
    clear_inputs();
    branch(5'd3, 5'd9, 1'b1);
    regFileRt  = 32'h0000_0077;
    exRegWrite = 1'b1;
    exMemRead  = 1'b1;
    exWriteReg = 5'd9;
    sample();
    check("ld_ex_stall0", 32'(stallOutput), 32'd1);
    check("ld_ex_bubble0", 32'(bubbleOutput), 32'd1);
    tick();
    exRegWrite   = 1'b0;
    exMemRead    = 1'b0;
    exWriteReg   = 5'd0;
    memRegWrite  = 1'b1;
    memMemRead   = 1'b1;
    memWriteReg  = 5'd9;
    memAluResult = 32'h0000_0100;
    sample();
    check("ld_ex_stall1", 32'(stallOutput), 32'd1);
    check("ld_mem_no_fwd_rt", dataRtOutput, 32'h0000_0077);
    tick();
    memRegWrite = 1'b0;
    memMemRead  = 1'b0;
    memWriteReg = 5'd0;
    wbRegWrite  = 1'b1;
    wbWriteReg  = 5'd9;
    wbWriteData = 32'h0000_CAFE;
    sample();
    check("ld_ex_release", 32'(stallOutput), 32'd0);
    check("ld_wb_fwd_rt", dataRtOutput, 32'h0000_CAFE);
    tick();

    // rt hazard ignored when the branch does not read rt
    clear_inputs();
    branch(5'd3, 5'd9, 1'b0);
    exRegWrite = 1'b1;
    exMemRead  = 1'b1;
    exWriteReg = 5'd9;
    sample();
    check("rt_unused_stall", 32'(stallOutput), 32'd0);
    tick();

    // no stall for an invalid ID slot or a non-branch
    clear_inputs();
    branch(5'd9, 5'd0, 1'b0);
    idValid    = 1'b0;
    exRegWrite = 1'b1;
    exMemRead  = 1'b1;
    exWriteReg = 5'd9;
    sample();
    check("invalid_stall", 32'(stallOutput), 32'd0);
    tick();
    idValid    = 1'b1;
    idIsBranch = 1'b0;
    sample();
    check("nonbranch_stall", 32'(stallOutput), 32'd0);
    tick();

    // 4: ALU write to r10 in EX -> one hold cycle, then MEM forward
    clear_inputs();
    branch(5'd10, 5'd0, 1'b0);
    exRegWrite = 1'b1;
    exWriteReg = 5'd10;
    sample();
    check("alu_ex_stall", 32'(stallOutput), 32'd1);
    tick();
    exRegWrite   = 1'b0;
    exWriteReg   = 5'd0;
    memRegWrite  = 1'b1;
    memWriteReg  = 5'd10;
    memAluResult = 32'h0000_1234;
    sample();
    check("alu_ex_release", 32'(stallOutput), 32'd0);
    check("alu_mem_fwd_rs", dataRsOutput, 32'h0000_1234);
    tick();

    // load two ahead (in MEM) -> one hold cycle, then WB forward
    clear_inputs();
    branch(5'd13, 5'd0, 1'b0);
    memRegWrite  = 1'b1;
    memMemRead   = 1'b1;
    memWriteReg  = 5'd13;
    memAluResult = 32'h0000_0200;
    regFileRs    = 32'h0000_0011;
    sample();
    check("ld_mem_stall", 32'(stallOutput), 32'd1);
    check("ld_mem_rs_regfile", dataRsOutput, 32'h0000_0011);
    tick();
    memRegWrite = 1'b0;
    memMemRead  = 1'b0;
    memWriteReg = 5'd0;
    wbRegWrite  = 1'b1;
    wbWriteReg  = 5'd13;
    wbWriteData = 32'h0000_5555;
    sample();
    check("ld_mem_release", 32'(stallOutput), 32'd0);
    check("ld_mem_wb_fwd", dataRsOutput, 32'h0000_5555);
    tick();

    // 5: every writer targets r0 -> no hazard, no forwarding
    clear_inputs();
    branch(5'd0, 5'd0, 1'b1);
    exRegWrite   = 1'b1;
    exMemRead    = 1'b1;
    memRegWrite  = 1'b1;
    memAluResult = 32'h0000_AAAA;
    wbRegWrite   = 1'b1;
    wbWriteData  = 32'h0000_BBBB;
    sample();
    check("r0_stall", 32'(stallOutput), 32'd0);
    check("r0_rs", dataRsOutput, 32'h0);
    check("r0_rt", dataRtOutput, 32'h0);
    tick();

    // 6: MEM and WB both write r11 -> MEM wins
    clear_inputs();
    branch(5'd11, 5'd11, 1'b1);
    memRegWrite  = 1'b1;
    memWriteReg  = 5'd11;
    memAluResult = 32'h0000_000A;
    wbRegWrite   = 1'b1;
    wbWriteReg   = 5'd11;
    wbWriteData  = 32'h0000_000B;
    sample();
    check("prio_rs", dataRsOutput, 32'h0000_000A);
    check("prio_rt", dataRtOutput, 32'h0000_000A);
    check("prio_stall", 32'(stallOutput), 32'd0);
    tick();
    // MEM is now a load: WB data is forwarded and the MEM load forces a hold
    memMemRead = 1'b1;
    sample();
    check("prio_ld_rs", dataRsOutput, 32'h0000_000B);
    check("prio_ld_stall", 32'(stallOutput), 32'd1);
    tick();

    // STALL ignores inputs, then returns to IDLE
    clear_inputs();
    branch(5'd12, 5'd0, 1'b0);
    exRegWrite = 1'b1;
    exMemRead  = 1'b1;
    exWriteReg = 5'd12;
    sample();
    check("stall_in_entry", 32'(stallOutput), 32'd1);
    tick();
    clear_inputs();
    sample();
    check("stall_ignores_in", 32'(stallOutput), 32'd1);
    tick();
    sample();
    check("stall_exit", 32'(stallOutput), 32'd0);
    tick();

    // reset asserted while in STALL
    branch(5'd12, 5'd0, 1'b0);
    exRegWrite = 1'b1;
    exMemRead  = 1'b1;
    exWriteReg = 5'd12;
    sample();
    check("rst_mid_entry", 32'(stallOutput), 32'd1);
    tick();
    clear_inputs();
    reset = 1'b1;
    sample();
    check("rst_mid_gated", 32'(stallOutput), 32'd0);
    tick();
    reset = 1'b0;
    sample();
    check("rst_mid_idle", 32'(stallOutput), 32'd0);
    check("rst_mid_bubble", 32'(bubbleOutput), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
